// File: rtl/lane_incr_fifo_if.sv
// lane_incr_fifo_if
//   Handshake bundle for lane_incr_fifo: the input transaction side
//   (in_valid/in_ready/in_op/in_data) and the buffered result side
//   (out_valid/out_ready/out_data/out_ovf).
//   master : producer of transactions / consumer of results
//   slave  : the increment engine itself
interface lane_incr_fifo_if #(
    parameter int WIDTH = 40,
    parameter int LANES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             in_op;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_ovf;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/lane_incr_fifo.sv
// lane_incr_fifo
//   Multi-lane increment/decrement engine. Every accepted transaction
//   updates LANES operands of WIDTH bits (pass, +1, -1, clear) in wrap or
//   saturate mode and queues the results plus per-lane overflow flags in a
//   DEPTH-entry FIFO.
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   bus        : lane_incr_fifo_if.slave (input handshake + result FIFO head)
//   ovf_clr    : clears ovf_sticky (a simultaneous overflow still sets)
//   ovf_sticky : per-lane OR of overflow events since last clear
//   txn_count  : count of accepted transactions, wraps
module lane_incr_fifo #(
    parameter int WIDTH    = 40,
    parameter int LANES    = 4,
    parameter int DEPTH    = 4,
    parameter bit SATURATE = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    lane_incr_fifo_if.slave  bus,
    input  logic             ovf_clr,
    output logic [LANES-1:0] ovf_sticky,
    output logic [CNT_W-1:0] txn_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Returns {ovf, result} for one lane.
    function automatic logic [WIDTH:0] lane_update(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH:0] r;
        r = {1'b0, d};
        case (op)
            2'b01: begin
                if (&d) r = {1'b1, (SATURATE ? {WIDTH{1'b1}} : {WIDTH{1'b0}})};
                else    r = {1'b0, d + 1'b1};
            end
            2'b10: begin
                if (d == '0) r = {1'b1, (SATURATE ? {WIDTH{1'b0}} : {WIDTH{1'b1}})};
                else         r = {1'b0, d - 1'b1};
            end
            2'b11:   r = '0;
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

    logic [LANES*WIDTH-1:0] mem_data [DEPTH];
    logic [LANES-1:0]       mem_ovf  [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [OCC_W-1:0]       occ;
    logic [OCC_W-1:0]       occ_next;
    logic                   in_ready_q;
    logic                   push;
    logic                   pop;

    logic [LANES*WIDTH-1:0] res_p0;
    logic [LANES-1:0]       ovf_p0;
    logic [WIDTH:0]         upd;

    // ---- stage p0: combinational lane update of the offered transaction ----
    always_comb begin
        res_p0 = '0;
        ovf_p0 = '0;
        upd    = '0;
        for (int i = 0; i < LANES; i++) begin
            upd = lane_update(bus.in_op, bus.in_data[i*WIDTH +: WIDTH]);
            res_p0[i*WIDTH +: WIDTH] = upd[WIDTH-1:0];
            ovf_p0[i]                = upd[WIDTH];
        end
    end

    assign push = bus.in_valid && in_ready_q;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        occ_next = occ;
        if (push && !pop)      occ_next = occ + 1'b1;
        else if (!push && pop) occ_next = occ - 1'b1;
    end

    // ---- stage p1: FIFO storage and control ----
    // in_ready is registered from the next occupancy, so a pop on a full
    // FIFO only reopens the input on the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            in_ready_q <= 1'b0;
            txn_count  <= '0;
            ovf_sticky <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_ovf[i]  <= '0;
            end
        end else begin
            occ        <= occ_next;
            in_ready_q <= (occ_next != OCC_FULL);
            if (push) begin
                mem_data[wr_ptr] <= res_p0;
                mem_ovf[wr_ptr]  <= ovf_p0;
                wr_ptr           <= wr_ptr + 1'b1;
                txn_count        <= txn_count + 1'b1;
                // New overflow events win over a same-cycle clear.
                ovf_sticky       <= (ovf_clr ? '0 : ovf_sticky) | ovf_p0;
            end else if (ovf_clr) begin
                ovf_sticky <= '0;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (occ != '0);
    assign bus.out_data  = mem_data[rd_ptr];
    assign bus.out_ovf   = mem_ovf[rd_ptr];
endmodule

// File: tb/tb_lane_incr_fifo.sv
// tb_lane_incr_fifo
//   Directed bench for lane_incr_fifo. dut0 runs in wrap mode, dut1 in
//   saturate mode; both share clock and reset.
module tb_lane_incr_fifo;
    localparam int W = 40;
    localparam int L = 4;
    localparam logic [W-1:0] ONES = 40'hFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ovf_clr0, ovf_clr1;
    logic [L-1:0]  sticky0, sticky1;
    logic [15:0]   txn0, txn1;
    logic [L*W-1:0] exp_d;
    int tests_run = 0;
    int tests_failed = 0;

    lane_incr_fifo_if #(.WIDTH(W), .LANES(L)) bus0 ();
    lane_incr_fifo_if #(.WIDTH(W), .LANES(L)) bus1 ();

    lane_incr_fifo #(.WIDTH(W), .LANES(L), .DEPTH(4), .SATURATE(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .ovf_clr(ovf_clr0),
        .ovf_sticky(sticky0), .txn_count(txn0)
    );
    lane_incr_fifo #(.WIDTH(W), .LANES(L), .DEPTH(4), .SATURATE(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .ovf_clr(ovf_clr1),
        .ovf_sticky(sticky1), .txn_count(txn1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [L*W-1:0] mk(input int k);
        logic [L*W-1:0] v;
        for (int i = 0; i < L; i++) v[i*W +: W] = W'(k * 16 + i);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus0.in_valid = 0; bus0.in_op = 0; bus0.in_data = '0; bus0.out_ready = 0;
        bus1.in_valid = 0; bus1.in_op = 0; bus1.in_data = '0; bus1.out_ready = 0;
        ovf_clr0 = 0; ovf_clr1 = 0;
        #1 reset = 1;
        #1;
        tests_run++; if (bus0.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready got %b want 0", bus0.in_ready); end
        tests_run++; if (bus0.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got %b want 0", bus0.out_valid); end
        tests_run++; if (bus0.out_data !== '0) begin tests_failed++; $display("FAIL rst_out_data got %h want 0", bus0.out_data); end
        tests_run++; if (bus0.out_ovf !== 4'b0) begin tests_failed++; $display("FAIL rst_out_ovf got %b want 0", bus0.out_ovf); end
        tests_run++; if (sticky0 !== 4'b0) begin tests_failed++; $display("FAIL rst_sticky got %b want 0", sticky0); end
        tests_run++; if (txn0 !== 16'd0) begin tests_failed++; $display("FAIL rst_txn got %0d want 0", txn0); end
        @(posedge clk); #1 reset = 0;
        tests_run++; if (bus0.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_release_ready got %b want 0", bus0.in_ready); end
        step();
        tests_run++; if (bus0.in_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_rst got %b want 1", bus0.in_ready); end
        tests_run++; if (bus1.in_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_rst1 got %b want 1", bus1.in_ready); end
    endtask

    task automatic test_single_incr();
        bus0.in_data = {40'h7F, ONES, 40'd5, 40'd0};
        bus0.in_op = 2'b01; bus0.in_valid = 1;
        step();
        bus0.in_valid = 0;
        exp_d = {40'h80, 40'd0, 40'd6, 40'd1};
        tests_run++; if (bus0.out_valid !== 1'b1) begin tests_failed++; $display("FAIL incr_valid got %b want 1", bus0.out_valid); end
        tests_run++; if (bus0.out_data !== exp_d) begin tests_failed++; $display("FAIL incr_data got %h want %h", bus0.out_data, exp_d); end
        tests_run++; if (bus0.out_ovf !== 4'b0100) begin tests_failed++; $display("FAIL incr_ovf got %b want 0100", bus0.out_ovf); end
        tests_run++; if (sticky0 !== 4'b0100) begin tests_failed++; $display("FAIL incr_sticky got %b want 0100", sticky0); end
        tests_run++; if (txn0 !== 16'd1) begin tests_failed++; $display("FAIL incr_txn got %0d want 1", txn0); end
        bus0.out_ready = 1;
        step();
        bus0.out_ready = 0;
        tests_run++; if (bus0.out_valid !== 1'b0) begin tests_failed++; $display("FAIL incr_pop_empty got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_saturate();
        bus1.in_data = {40'd9, 40'd0, 40'd1, 40'd0};
        bus1.in_op = 2'b10; bus1.in_valid = 1;
        step();
        bus1.in_data = {40'h1234, ONES, 40'd77, 40'd3};
        bus1.in_op = 2'b11;
        step();
        bus1.in_valid = 0;
        exp_d = {40'd8, 40'd0, 40'd0, 40'd0};
        tests_run++; if (bus1.out_data !== exp_d) begin tests_failed++; $display("FAIL sat_dec_data got %h want %h", bus1.out_data, exp_d); end
        tests_run++; if (bus1.out_ovf !== 4'b0101) begin tests_failed++; $display("FAIL sat_dec_ovf got %b want 0101", bus1.out_ovf); end
        bus1.out_ready = 1;
        step();
        tests_run++; if (bus1.out_data !== '0) begin tests_failed++; $display("FAIL sat_clr_data got %h want 0", bus1.out_data); end
        tests_run++; if (bus1.out_ovf !== 4'b0) begin tests_failed++; $display("FAIL sat_clr_ovf got %b want 0", bus1.out_ovf); end
        tests_run++; if (bus1.out_valid !== 1'b1) begin tests_failed++; $display("FAIL sat_clr_valid got %b want 1", bus1.out_valid); end
        step();
        bus1.out_ready = 0;
        tests_run++; if (bus1.out_valid !== 1'b0) begin tests_failed++; $display("FAIL sat_drain got %b want 0", bus1.out_valid); end
        tests_run++; if (sticky1 !== 4'b0101) begin tests_failed++; $display("FAIL sat_sticky got %b want 0101", sticky1); end
        tests_run++; if (txn1 !== 16'd2) begin tests_failed++; $display("FAIL sat_txn got %0d want 2", txn1); end
    endtask

    task automatic test_back_to_back();
        bus0.in_op = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            bus0.in_data = mk(k); bus0.in_valid = 1;
            step();
        end
        tests_run++; if (bus0.in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready got %b want 0", bus0.in_ready); end
        tests_run++; if (txn0 !== 16'd5) begin tests_failed++; $display("FAIL full_txn got %0d want 5", txn0); end
        bus0.in_data = mk(5);
        step();
        step();
        tests_run++; if (bus0.in_ready !== 1'b0) begin tests_failed++; $display("FAIL held_ready got %b want 0", bus0.in_ready); end
        tests_run++; if (txn0 !== 16'd5) begin tests_failed++; $display("FAIL held_txn got %0d want 5", txn0); end
        tests_run++; if (bus0.out_data !== mk(1)) begin tests_failed++; $display("FAIL held_head got %h want %h", bus0.out_data, mk(1)); end
        // full FIFO, pop and offer in the same cycle: no accept
        bus0.out_ready = 1;
        step();
        tests_run++; if (txn0 !== 16'd5) begin tests_failed++; $display("FAIL fullpop_txn got %0d want 5", txn0); end
        tests_run++; if (bus0.in_ready !== 1'b1) begin tests_failed++; $display("FAIL fullpop_ready got %b want 1", bus0.in_ready); end
        tests_run++; if (bus0.out_data !== mk(2)) begin tests_failed++; $display("FAIL drain_2 got %h want %h", bus0.out_data, mk(2)); end
        step();
        bus0.in_valid = 0;
        tests_run++; if (txn0 !== 16'd6) begin tests_failed++; $display("FAIL accept5_txn got %0d want 6", txn0); end
        for (int k = 3; k <= 5; k++) begin
            tests_run++; if (bus0.out_data !== mk(k) || bus0.out_valid !== 1'b1) begin tests_failed++; $display("FAIL drain_%0d got %h v=%b want %h", k, bus0.out_data, bus0.out_valid, mk(k)); end
            step();
        end
        bus0.out_ready = 0;
        tests_run++; if (bus0.out_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_sticky_clr();
        bus0.in_data = {40'd0, 40'd0, 40'd0, ONES};
        bus0.in_op = 2'b01; bus0.in_valid = 1; ovf_clr0 = 1;
        step();
        bus0.in_valid = 0;
        tests_run++; if (sticky0 !== 4'b0001) begin tests_failed++; $display("FAIL clr_set_sticky got %b want 0001", sticky0); end
        tests_run++; if (bus0.out_ovf !== 4'b0001) begin tests_failed++; $display("FAIL clr_set_ovf got %b want 0001", bus0.out_ovf); end
        step();
        ovf_clr0 = 0;
        tests_run++; if (sticky0 !== 4'b0000) begin tests_failed++; $display("FAIL clr_alone got %b want 0000", sticky0); end
        bus0.out_ready = 1;
        step();
        bus0.out_ready = 0;
        tests_run++; if (txn0 !== 16'd7) begin tests_failed++; $display("FAIL clr_txn got %0d want 7", txn0); end
    endtask

    task automatic test_reset_midop();
        #1 reset = 1;
        #1 reset = 0;
        step();
        bus0.in_data = {ONES, ONES, ONES, ONES};
        bus0.in_op = 2'b01; bus0.in_valid = 1;
        step(); step(); step();
        bus0.in_valid = 0;
        tests_run++; if (txn0 !== 16'd3) begin tests_failed++; $display("FAIL mid_txn got %0d want 3", txn0); end
        tests_run++; if (sticky0 !== 4'b1111) begin tests_failed++; $display("FAIL mid_sticky got %b want 1111", sticky0); end
        #2 reset = 1;
        #1;
        tests_run++; if (bus0.out_valid !== 1'b0) begin tests_failed++; $display("FAIL async_valid got %b want 0", bus0.out_valid); end
        tests_run++; if (txn0 !== 16'd0) begin tests_failed++; $display("FAIL async_txn got %0d want 0", txn0); end
        tests_run++; if (sticky0 !== 4'b0) begin tests_failed++; $display("FAIL async_sticky got %b want 0", sticky0); end
        tests_run++; if (bus0.out_data !== '0) begin tests_failed++; $display("FAIL async_data got %h want 0", bus0.out_data); end
        reset = 0;
        step();
        bus0.in_data = mk(7); bus0.in_op = 2'b00; bus0.in_valid = 1;
        step();
        bus0.in_valid = 0;
        tests_run++; if (bus0.out_data !== mk(7)) begin tests_failed++; $display("FAIL post_rst_data got %h want %h", bus0.out_data, mk(7)); end
        bus0.out_ready = 1;
        step();
        bus0.out_ready = 0;
        tests_run++; if (bus0.out_valid !== 1'b0) begin tests_failed++; $display("FAIL post_rst_only got %b want 0", bus0.out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_incr();
        test_saturate();
        test_back_to_back();
        test_sticky_clr();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
